// File: rtl/mat_addr_gen_if.sv
// Address stream from mat_addr_gen to an operand memory: valid/ready handshake
// with a last-address flag.
interface mat_addr_gen_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;
    logic              addr_last;

    modport master (output addr, output addr_valid, output addr_last, input addr_ready);
    modport slave  (input addr, input addr_valid, input addr_last, output addr_ready);
endinterface

// File: rtl/mat_addr_gen.sv
// Matrix address generator: sweeps a ROWS x COLS row-major matrix at a latched base,
// row- or column-major per run. Optional repeat passes under MAT_ADDR_GEN_REPEAT_EN.
module mat_addr_gen #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base,
`ifdef MAT_ADDR_GEN_REPEAT_EN
    input  logic [7:0]        rep_cnt,
`endif
    output logic              busy,
    output logic              done,
    mat_addr_gen_if.master    stream
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [RW-1:0]     r;
    logic [CW-1:0]     c;
    logic              mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] offset;
    logic              load, step, handshake;
    logic              r_end, c_end, pass_end, at_last;

`ifdef MAT_ADDR_GEN_REPEAT_EN
    logic [7:0] rep_q;
    logic [7:0] pass;
    assign pass_end = (pass == rep_q);
`else
    assign pass_end = 1'b1;
`endif

    assign r_end     = (r == R_MAX);
    assign c_end     = (c == C_MAX);
    assign at_last   = r_end && c_end && pass_end;
    assign handshake = stream.addr_valid && stream.addr_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (handshake) begin
                    // The final address is held through DONE, so counters stop on it.
                    step = !at_last;
                    if (at_last) state_n = DONE;
                end
            end
            DONE: begin
                load    = start;
                state_n = start ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r      <= '0;
            c      <= '0;
            mode_q <= 1'b0;
            base_q <= '0;
`ifdef MAT_ADDR_GEN_REPEAT_EN
            rep_q  <= '0;
            pass   <= '0;
`endif
        end else if (load) begin
            r      <= '0;
            c      <= '0;
            mode_q <= mode;
            base_q <= base;
`ifdef MAT_ADDR_GEN_REPEAT_EN
            rep_q  <= rep_cnt;
            pass   <= '0;
`endif
        end else if (step) begin
            if (!mode_q) begin
                c <= c_end ? '0 : c + 1'b1;
                if (c_end) r <= r_end ? '0 : r + 1'b1;
            end else begin
                r <= r_end ? '0 : r + 1'b1;
                if (r_end) c <= c_end ? '0 : c + 1'b1;
            end
`ifdef MAT_ADDR_GEN_REPEAT_EN
            // Both indices wrap together at the end of a non-final pass.
            if (r_end && c_end) pass <= pass + 1'b1;
`endif
        end
    end

    // Arithmetic at ADDR_W bits gives the modulo-2^ADDR_W wrap for free.
    assign offset = ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);

    assign busy              = (state == RUN);
    assign done              = (state == DONE);
    assign stream.addr       = base_q + offset;
    assign stream.addr_valid = busy;
    assign stream.addr_last  = busy && at_last;
endmodule

// File: tb/tb_mat_addr_gen.sv
// Scoreboard bench for mat_addr_gen: an 8x8 and a 3x5 instance, random runs checked
// against a loop-based address model; repeat runs only with MAT_ADDR_GEN_REPEAT_EN.
module tb_mat_addr_gen;
    localparam int AW     = 8;
    localparam int ROWS_A = 8;
    localparam int COLS_A = 8;
    localparam int ROWS_B = 3;
    localparam int COLS_B = 5;

    typedef struct {
        logic [AW-1:0] a;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_r [2];
    logic          mode_r  [2];
    logic [AW-1:0] base_r  [2];
    logic          ready   [2];
`ifdef MAT_ADDR_GEN_REPEAT_EN
    logic [7:0]    rep_r   [2];
`endif
    logic [AW-1:0] m_addr  [2];
    logic          m_valid [2];
    logic          m_last  [2];
    logic          m_busy  [2];
    logic          m_done  [2];

    exp_t          exp_q [2][$];
    exp_t          e;
    int            hs         [2] = '{0, 0};
    int            done_cnt   [2] = '{0, 0};
    int            pct        [2] = '{100, 100};
    int            stall_at   [2] = '{0, 0};
    int            stall_left [2] = '{0, 0};
    logic          prev_last  [2];
    logic          prev_stall [2];
    logic          held_last  [2];
    logic [AW-1:0] held_addr  [2];
    int            vectors     = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    mat_addr_gen_if #(.ADDR_W(AW)) if_a ();
    mat_addr_gen_if #(.ADDR_W(AW)) if_b ();

    assign if_a.addr_ready = ready[0];
    assign if_b.addr_ready = ready[1];
    assign m_addr[0]  = if_a.addr;
    assign m_valid[0] = if_a.addr_valid;
    assign m_last[0]  = if_a.addr_last;
    assign m_addr[1]  = if_b.addr;
    assign m_valid[1] = if_b.addr_valid;
    assign m_last[1]  = if_b.addr_last;

    mat_addr_gen #(.ROWS(ROWS_A), .COLS(COLS_A), .ADDR_W(AW)) u_a (
        .clk     (clk),
        .reset   (reset),
        .start   (start_r[0]),
        .mode    (mode_r[0]),
        .base    (base_r[0]),
`ifdef MAT_ADDR_GEN_REPEAT_EN
        .rep_cnt (rep_r[0]),
`endif
        .busy    (m_busy[0]),
        .done    (m_done[0]),
        .stream  (if_a.master)
    );

    mat_addr_gen #(.ROWS(ROWS_B), .COLS(COLS_B), .ADDR_W(AW)) u_b (
        .clk     (clk),
        .reset   (reset),
        .start   (start_r[1]),
        .mode    (mode_r[1]),
        .base    (base_r[1]),
`ifdef MAT_ADDR_GEN_REPEAT_EN
        .rep_cnt (rep_r[1]),
`endif
        .busy    (m_busy[1]),
        .done    (m_done[1]),
        .stream  (if_b.master)
    );

    function automatic int rows_of(input int k);
        return (k == 0) ? ROWS_A : ROWS_B;
    endfunction

    function automatic int cols_of(input int k);
        return (k == 0) ? COLS_A : COLS_B;
    endfunction

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Reference: enumerate the i-th element of each pass and derive (r,c) by division.
    function automatic void push_run(input int k, input logic [AW-1:0] b, input logic m, input int rep);
        int   rows, cols, n, r, c;
        exp_t x;
        rows = rows_of(k);
        cols = cols_of(k);
        n    = rows * cols;
        for (int p = 0; p <= rep; p++) begin
            for (int i = 0; i < n; i++) begin
                if (m) begin r = i % rows; c = i / rows; end
                else   begin r = i / cols; c = i % cols; end
                x.a    = AW'((int'(b) + r * cols + c) % (1 << AW));
                x.last = (p == rep) && (i == n - 1);
                exp_q[k].push_back(x);
            end
        end
    endfunction

    task automatic wait_hs(input int k, input int n);
        int t = 0;
        while (hs[k] < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("hs_reached", k, 32'(hs[k] >= n), 1);
    endtask

    task automatic wait_done(input int k, input int target);
        int t = 0;
        while (done_cnt[k] < target && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_seen", k, 32'(done_cnt[k] >= target), 1);
    endtask

    // One run: load expectations, pulse start, scramble inputs that must be latched.
    task automatic run(input int k, input logic [AW-1:0] b, input logic m, input int rep,
                       input int p, input bit repulse);
        int d0;
        push_run(k, b, m, rep);
        hs[k]  = 0;
        pct[k] = p;
        d0     = done_cnt[k];
        base_r[k] = b;
        mode_r[k] = m;
`ifdef MAT_ADDR_GEN_REPEAT_EN
        rep_r[k] = 8'(rep);
`endif
        start_r[k] = 1'b1;
        @(posedge clk); #1;
        start_r[k] = 1'b0;
        base_r[k]  = AW'($urandom);
        mode_r[k]  = 1'($urandom);
`ifdef MAT_ADDR_GEN_REPEAT_EN
        rep_r[k] = 8'($urandom_range(0, 3));
`endif
        if (repulse) begin
            wait_hs(k, 4);
            start_r[k] = 1'b1;
            @(posedge clk); #1;
            start_r[k] = 1'b0;
        end
        wait_done(k, d0 + 1);
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", k, done_cnt[k], d0 + 1);
        check("hs_total", k, hs[k], (rep + 1) * rows_of(k) * cols_of(k));
        check("queue_left", k, exp_q[k].size(), 0);
    endtask

    // Ready driver: random acceptance, plus a scripted stall at a given handshake index.
    initial begin
        ready[0] = 1'b0;
        ready[1] = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (stall_left[k] > 0 && hs[k] == stall_at[k]) begin
                    ready[k] = 1'b0;
                    stall_left[k]--;
                end else begin
                    ready[k] = ($urandom_range(99) < pct[k]);
                end
            end
        end
    end

    // Monitor: mid-cycle sampling; a handshake seen here completes at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int k = 0; k < 2; k++) begin
                    prev_last[k]  = 1'b0;
                    prev_stall[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (prev_stall[k]) begin
                        check("hold_valid", k, m_valid[k], 1);
                        check("hold_addr", k, m_addr[k], held_addr[k]);
                        check("hold_last", k, m_last[k], held_last[k]);
                    end
                    check("done", k, m_done[k], prev_last[k]);
                    if (prev_last[k]) check("valid_in_done", k, m_valid[k], 0);
                    check("busy_vs_valid", k, m_busy[k], m_valid[k]);
                    if (m_done[k]) done_cnt[k]++;
                    prev_last[k] = 1'b0;
                    if (m_valid[k] && ready[k]) begin
                        hs[k]++;
                        if (exp_q[k].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL spurious_hs[%0d]: got addr 0x%0h, expected no handshake", k, m_addr[k]);
                        end else begin
                            e = exp_q[k].pop_front();
                            check("addr", k, m_addr[k], e.a);
                            check("last", k, m_last[k], e.last);
                            prev_last[k] = e.last;
                        end
                    end
                    prev_stall[k] = m_valid[k] && !ready[k];
                    held_addr[k]  = m_addr[k];
                    held_last[k]  = m_last[k];
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_r[k] = 1'b0;
            mode_r[k]  = 1'b0;
            base_r[k]  = '0;
`ifdef MAT_ADDR_GEN_REPEAT_EN
            rep_r[k] = '0;
`endif
        end
        #1 reset = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            check("rst_addr", k, m_addr[k], 0);
            check("rst_valid", k, m_valid[k], 0);
            check("rst_last", k, m_last[k], 0);
            check("rst_busy", k, m_busy[k], 0);
            check("rst_done", k, m_done[k], 0);
        end
        #19 reset = 1'b1;
        @(posedge clk); #1;

        // Column-major, full rate.
        run(0, 8'h00, 1'b1, 0, 100, 1'b0);
        // Row-major with a three-cycle stall on the third address.
        stall_at[0]   = 2;
        stall_left[0] = 3;
        run(0, 8'h10, 1'b0, 0, 100, 1'b0);
        // Address wrap past 0xFF.
        run(0, 8'hF0, 1'b0, 0, 100, 1'b0);
        // Odd shape with start re-pulsed mid-run.
        run(1, 8'h00, 1'b1, 0, 100, 1'b1);

        // Start held high: restart straight out of DONE with inputs changed mid-run.
        begin : b2b
            int            d0;
            logic [AW-1:0] b2;
            logic          m2;
            b2 = AW'($urandom);
            m2 = 1'($urandom);
            push_run(0, 8'h33, 1'b0, 0);
            push_run(0, b2, m2, 0);
            hs[0]  = 0;
            pct[0] = 80;
            d0     = done_cnt[0];
            base_r[0]  = 8'h33;
            mode_r[0]  = 1'b0;
            start_r[0] = 1'b1;
            wait_hs(0, 1);
            base_r[0] = b2;
            mode_r[0] = m2;
            wait_done(0, d0 + 1);
            start_r[0] = 1'b0;
            wait_done(0, d0 + 2);
            repeat (2) @(posedge clk);
            #1;
            check("b2b_done_pulses", 0, done_cnt[0], d0 + 2);
            check("b2b_hs_total", 0, hs[0], 2 * ROWS_A * COLS_A);
            check("b2b_queue_left", 0, exp_q[0].size(), 0);
        end

        // Asynchronous abort after ten handshakes.
        begin : abort_t
            int d0;
            push_run(0, 8'h00, 1'b1, 0);
            hs[0]  = 0;
            pct[0] = 100;
            d0     = done_cnt[0];
            base_r[0]  = 8'h00;
            mode_r[0]  = 1'b1;
            start_r[0] = 1'b1;
            @(posedge clk); #1;
            start_r[0] = 1'b0;
            wait_hs(0, 10);
            #2 reset = 1'b0;
            #1;
            check("abort_addr", 0, m_addr[0], 0);
            check("abort_valid", 0, m_valid[0], 0);
            check("abort_last", 0, m_last[0], 0);
            check("abort_busy", 0, m_busy[0], 0);
            check("abort_done", 0, m_done[0], 0);
            exp_q[0].delete();
            repeat (2) @(posedge clk);
            #3 reset = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check("abort_no_done", 0, done_cnt[0], d0);
        end
        run(0, 8'h00, 1'($urandom), 0, 100, 1'b0);

        // Random runs on both shapes.
        for (int i = 0; i < 6; i++) begin
            run(i % 2, AW'($urandom), 1'($urandom), 0, $urandom_range(30, 100), 1'($urandom));
        end

`ifdef MAT_ADDR_GEN_REPEAT_EN
        run(0, 8'h00, 1'b1, 1, 100, 1'b0);
        run(1, AW'($urandom), 1'($urandom), $urandom_range(0, 3), 60, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
